// File: rtl/char_flush_scanner.sv
// ---------------------------------------------------------------------------
// char_flush_scanner
//
// Walks a scan position across the screen one pixel per clock, in row-major
// order with x fastest. The position goes out on flush_x/flush_y to the
// character glyph decoders. The merged colour/enable that comes back
// combinationally is registered into a one-cycle output stage that drives the
// VGA adapter's plot interface.
//
// Parameters
//   WIDTH      pixels per row    (1..256); flush_x runs 0..WIDTH-1
//   HEIGHT     rows per frame    (1..256); flush_y runs 0..HEIGHT-1
//   BG_COLOUR  colour plotted where no decoder asserts enable
//
// Ports
//   clk         system clock; all logic is rising-edge
//   resetn      synchronous active-low reset
//   start       single-cycle request to flush one frame (honoured in IDLE only)
//   in_colour   decoder-bank colour for the current flush_x/flush_y
//   in_enable   high when some glyph covers the current flush_x/flush_y
//   flush_x/y   scan coordinate presented to the decoders
//   vga_x/y     plot coordinate to the VGA adapter
//   vga_colour  plot colour
//   vga_plot    plot strobe; one pixel is written per high cycle
//   busy        high while a frame flush is in progress (SCAN and DRAIN)
//   done        one-cycle pulse when a frame completes
// ---------------------------------------------------------------------------
module char_flush_scanner #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [5:0] BG_COLOUR = 6'b000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [5:0] in_colour,
    input  logic       in_enable,
    output logic [7:0] flush_x,
    output logic [7:0] flush_y,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    // Last legal coordinates. WIDTH/HEIGHT may be 256, so the compare values
    // are formed as WIDTH-1 and HEIGHT-1. That keeps them inside 8 bits.
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] x_next;
    logic [7:0] y_next;

    // Output-stage registers. The names carry the stage they belong to.
    logic       vld_p1;
    logic [7:0] x_p1;
    logic [7:0] y_p1;
    logic [5:0] colour_p1;

    // Choose between the glyph colour and the background colour.
    function automatic logic [5:0] pick_colour(input logic       enable,
                                               input logic [5:0] colour);
        return enable ? colour : BG_COLOUR;
    endfunction

    // Next-state and scan-counter logic.
    always_comb begin
        state_next = state;
        x_next     = flush_x;
        y_next     = flush_y;

        unique case (state)
            IDLE: begin
                // Counters are already parked at the origin here, so the
                // first SCAN cycle presents (0,0).
                x_next = 8'd0;
                y_next = 8'd0;
                if (start) begin
                    state_next = SCAN;
                end
            end

            SCAN: begin
                if (flush_x == X_LAST) begin
                    x_next = 8'd0;
                    if (flush_y == Y_LAST) begin
                        // Last pixel is being presented this cycle. Its plot
                        // comes out of the output stage during DRAIN.
                        y_next     = 8'd0;
                        state_next = DRAIN;
                    end else begin
                        y_next = flush_y + 8'd1;
                    end
                end else begin
                    x_next = flush_x + 8'd1;
                end
            end

            DRAIN: begin
                state_next = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                x_next     = 8'd0;
                y_next     = 8'd0;
            end
        endcase
    end

    // Stage p0: FSM state and scan counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            flush_x <= 8'd0;
            flush_y <= 8'd0;
        end else begin
            state   <= state_next;
            flush_x <= x_next;
            flush_y <= y_next;
        end
    end

    // Stage p1: capture the decoder return for the coordinate presented in
    // the previous cycle. The plot is valid only when that cycle was SCAN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            x_p1      <= 8'd0;
            y_p1      <= 8'd0;
            colour_p1 <= 6'd0;
        end else begin
            vld_p1    <= (state == SCAN);
            x_p1      <= flush_x;
            y_p1      <= flush_y;
            colour_p1 <= pick_colour(in_enable, in_colour);
        end
    end

    assign vga_plot   = vld_p1;
    assign vga_x      = x_p1;
    assign vga_y      = y_p1;
    assign vga_colour = colour_p1;

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);

endmodule
